// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared constants and FSM state type for the Booth multiplier scheduler
package booth_pkg;

    localparam int BOOTH_N       = 4;
    localparam int FRAME_LEN_DEF = 2 * BOOTH_N + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth add/subtract followed by arithmetic right shift
module booth_step
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N
) (
    input  logic signed [N:0]   acc,
    input  logic        [N-1:0] q,
    input  logic                q_minus,
    input  logic signed [N-1:0] mcand,
    output logic signed [N:0]   acc_nxt,
    output logic        [N-1:0] q_nxt,
    output logic                q_minus_nxt
);

    logic signed [N:0] mcand_ext;
    logic signed [N:0] sum;

    // Recode the {Q[0], q_minus} pair, then shift {sum, Q, q_minus} right by one keeping the sign
    always_comb begin
        mcand_ext = {mcand[N-1], mcand};
        sum       = acc;
        case ({q[0], q_minus})
            2'b10:   sum = acc - mcand_ext;
            2'b01:   sum = acc + mcand_ext;
            default: sum = acc;
        endcase
        acc_nxt     = {sum[N], sum[N:1]};
        q_nxt       = {sum[0], q[N-1:1]};
        q_minus_nxt = q[0];
    end

endmodule

// File: rtl/booth_mult_sched.sv
// rtl/booth_mult_sched.sv - two-requester round-robin Booth multiplier with serial result frame
module booth_mult_sched
    import booth_pkg::*;
#(
    parameter int N         = BOOTH_N,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [1:0]            req,
    input  logic signed [N-1:0]   mplier0,
    input  logic signed [N-1:0]   mcand0,
    input  logic signed [N-1:0]   mplier1,
    input  logic signed [N-1:0]   mcand1,
    output logic [1:0]            gnt,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic signed [2*N-1:0] product,
    output logic                  tx
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int BIT_W = $clog2(FRAME_LEN);

    state_t              state;
    logic signed [N:0]   acc;
    logic [N-1:0]        q;
    logic                q_minus;
    logic signed [N-1:0] mcand_r;
    logic [CNT_W-1:0]    step_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [2*N-1:0]      tx_sr;
    logic                cur_id;
    logic                rr_ptr;

    logic                winner;
    logic signed [N:0]   acc_nxt;
    logic [N-1:0]        q_nxt;
    logic                q_minus_nxt;
    logic [2*N-1:0]      product_full;

    booth_step #(.N(N)) u_step (
        .acc         (acc),
        .q           (q),
        .q_minus     (q_minus),
        .mcand       (mcand_r),
        .acc_nxt     (acc_nxt),
        .q_nxt       (q_nxt),
        .q_minus_nxt (q_minus_nxt)
    );

    assign product_full = {acc_nxt[N-1:0], q_nxt};
    assign busy         = (state != IDLE);

    // Round-robin pick: the favoured requester wins if asking, otherwise the other one
    always_comb begin
        winner = req[rr_ptr] ? rr_ptr : ~rr_ptr;
    end

    // Scheduler FSM: grant and capture in IDLE, N Booth steps in CALC, serialize product in SEND.
    // The stop bit is driven during the first IDLE cycle so a pending request can be granted on
    // that same edge, keeping back-to-back jobs N + FRAME_LEN cycles apart.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            acc      <= '0;
            q        <= '0;
            q_minus  <= 1'b0;
            mcand_r  <= '0;
            step_cnt <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            cur_id   <= 1'b0;
            rr_ptr   <= 1'b0;
            gnt      <= 2'b00;
            done     <= 1'b0;
            done_id  <= 1'b0;
            product  <= '0;
            tx       <= 1'b1;
        end else begin
            gnt  <= 2'b00;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (|req) begin
                        acc      <= '0;
                        q        <= winner ? mplier1 : mplier0;
                        mcand_r  <= winner ? mcand1 : mcand0;
                        q_minus  <= 1'b0;
                        step_cnt <= '0;
                        cur_id   <= winner;
                        rr_ptr   <= ~winner;
                        gnt      <= winner ? 2'b10 : 2'b01;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc     <= acc_nxt;
                    q       <= q_nxt;
                    q_minus <= q_minus_nxt;
                    if (step_cnt == CNT_W'(N - 1)) begin
                        product <= product_full;
                        tx_sr   <= product_full;
                        done    <= 1'b1;
                        done_id <= cur_id;
                        tx      <= 1'b0;
                        bit_cnt <= '0;
                        state   <= SEND;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (bit_cnt == BIT_W'(FRAME_LEN - 2)) begin
                        tx    <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tx      <= tx_sr[0];
                        tx_sr   <= tx_sr >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_sched.sv
// tb/tb_booth_mult_sched.sv - directed self-checking bench for booth_mult_sched
module tb_booth_mult_sched;

    logic       CLK;
    logic       RST_N;
    logic [1:0] req;
    logic [3:0] mplier0, mcand0, mplier1, mcand1;
    logic [1:0] gnt;
    logic       busy, done, done_id;
    logic [7:0] product;
    logic       tx;

    int checks   = 0;
    int failures = 0;

    booth_mult_sched #(.N(4), .FRAME_LEN(10)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .req     (req),
        .mplier0 (mplier0),
        .mcand0  (mcand0),
        .mplier1 (mplier1),
        .mcand1  (mcand1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .product (product),
        .tx      (tx)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (gnt != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Runs one job from a lone requester and checks grant, done timing, product and the tx frame.
    // Operands are scrambled right after the grant to confirm they no longer matter.
    task automatic run_job(input logic id, input logic [3:0] mp, input logic [3:0] mc,
                           input logic [7:0] exp_p);
        logic [9:0] frame;
        logic       ok;
        frame = {1'b1, exp_p, 1'b0};
        if (id) begin
            mplier1 = mp; mcand1 = mc; req = 2'b10;
        end else begin
            mplier0 = mp; mcand0 = mc; req = 2'b01;
        end
        wait_gnt(ok);
        chk("job_gnt_seen", 16'(ok), 16'd1);
        chk("job_gnt", 16'(gnt), id ? 16'h2 : 16'h1);
        chk("job_busy_calc", 16'(busy), 16'd1);
        chk("job_tx_calc", 16'(tx), 16'd1);
        req = 2'b00;
        mplier0 = 4'($urandom); mcand0 = 4'($urandom);
        mplier1 = 4'($urandom); mcand1 = 4'($urandom);
        @(negedge CLK);
        chk("job_gnt_pulse", 16'(gnt), 16'h0);
        @(negedge CLK);
        @(negedge CLK);
        chk("job_done_early", 16'(done), 16'd0);
        @(negedge CLK);
        chk("job_done", 16'(done), 16'd1);
        chk("job_product", 16'(product), 16'(exp_p));
        chk("job_done_id", 16'(done_id), 16'(id));
        chk("job_tx_start", 16'(tx), 16'(frame[0]));
        for (int k = 1; k < 10; k++) begin
            @(negedge CLK);
            chk($sformatf("job_tx_bit%0d", k), 16'(tx), 16'(frame[k]));
            chk("job_busy_frame", 16'(busy), (k < 9) ? 16'd1 : 16'd0);
            if (k == 1) chk("job_done_width", 16'(done), 16'd0);
        end
        chk("job_product_hold", 16'(product), 16'(exp_p));
    endtask

    initial begin
        logic       ok;
        int         ngr;
        int         ndone;
        int         last_cyc;
        logic       last_id;

        RST_N = 1'b0; req = 2'b00;
        mplier0 = 4'h0; mcand0 = 4'h0; mplier1 = 4'h0; mcand1 = 4'h0;
        repeat (3) @(negedge CLK);
        chk("rst_tx", 16'(tx), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_gnt", 16'(gnt), 16'h0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_done_id", 16'(done_id), 16'd0);
        chk("rst_product", 16'(product), 16'h0);
        RST_N = 1'b1;
        @(negedge CLK);

        // 3 * -2 = -6
        run_job(1'b0, 4'h3, 4'hE, 8'hFA);
        // -8 * -8 = +64, lone requester 0 wins again despite pointer favouring 1
        run_job(1'b0, 4'h8, 4'h8, 8'h40);
        // -1 * 7 = -7
        run_job(1'b1, 4'hF, 4'h7, 8'hF9);

        // Contention: both requesting from reset
        RST_N = 1'b0;
        req = 2'b11;
        mplier0 = 4'h2; mcand0 = 4'h3;
        mplier1 = 4'hD; mcand1 = 4'h5;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        ngr = 0; ndone = 0; last_cyc = 0; last_id = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge CLK);
            if (gnt != 2'b00) begin
                chk("cont_gnt", 16'(gnt), ngr[0] ? 16'h2 : 16'h1);
                if (ngr > 0) chk("cont_spacing", 16'(cyc - last_cyc), 16'd14);
                last_cyc = cyc;
                last_id  = gnt[1];
                ngr++;
                if (ngr == 4) req = 2'b00;
            end
            if (done) begin
                ndone++;
                chk("cont_done_id", 16'(done_id), 16'(last_id));
                chk("cont_product", 16'(product), last_id ? 16'h00F1 : 16'h0006);
            end
            if (ngr == 4 && (cyc - last_cyc) >= 13 && !busy) break;
        end
        chk("cont_grants", 16'(ngr), 16'd4);
        chk("cont_dones", 16'(ndone), 16'd4);

        // Abort during SEND bit 4; 3 * 2 = 6 so bit 4 of the frame is product[3] = 0
        @(negedge CLK);
        mplier1 = 4'h3; mcand1 = 4'h2; req = 2'b10;
        wait_gnt(ok);
        chk("abort_gnt_seen", 16'(ok), 16'd1);
        chk("abort_gnt", 16'(gnt), 16'h2);
        req = 2'b00;
        repeat (8) @(negedge CLK);
        chk("abort_tx_bit4", 16'(tx), 16'd0);
        chk("abort_busy_pre", 16'(busy), 16'd1);
        RST_N = 1'b0;
        #1;
        chk("abort_tx_async", 16'(tx), 16'd1);
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_product", 16'(product), 16'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (done || busy || !tx) ndone++;
        end
        chk("abort_quiet", 16'(ndone), 16'd0);
        run_job(1'b1, 4'h3, 4'hE, 8'hFA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
